multicycle_datapath: RTL
========================

# multicycle_datapath

Register-transfer datapath of the multicycle CPU: PC, IR, MDR, A, B and ALUOut registers, a 32×32-bit register file, and the ALU. It is the consumer end of the control-signal interface. It applies the per-cycle control word from the control FSM, exposes opcode, funct and the zero flag back to the FSM, and drives a single unified instruction/data memory port.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- i_clk  in  1  clock; all state updates on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_PCWrite, i_PCWriteCond, i_IorD, i_MemRead, i_MemWrite, i_MemtoReg, i_IRWrite, i_RegWrite  in  1 each  control strobes/selects from FSM
- i_PCSource, i_ALUSrcA, i_ALUSrcB, i_RegDst  in  2 each  mux selects
- i_ALUOp  in  3  ALU operation
- o_op  out  6  IR[31:26]
- o_funct  out  6  IR[5:0]
- o_zero  out  1  combinational; 1 when current ALU result == 0
- o_mem_addr  out  32  IorD ? ALUOut : PC
- o_mem_wdata  out  32  register B
- o_mem_rd, o_mem_wr  out  1  i_MemRead / i_MemWrite passed through combinationally
- i_mem_rdata  in  32  memory read data, valid in the same cycle as o_mem_addr (combinational read)
- o_pc, o_ir  out  32  debug views of PC and IR

## Operation
- ALU input A (ALUSrcA): 00 PC, 01 A, 10 MDR, 11 constant 4.
- ALU input B (ALUSrcB): 00 B, 01 constant 4, 10 immediate, 11 sign-ext(IR[15:0])<<2.
- Immediate for ALUSrcB=10: zero-extended IR[15:0] when o_op=6'b001100 (ANDI). Sign-extended otherwise.
- ALUOp: 000 add, 001 sub, 010 or, 011 and, 100 slt (signed; result 32'd1 or 32'd0). 101–111 give result 0.
- Arithmetic is 32-bit modulo 2^32. No overflow detection.
- Register file write address (RegDst): 00 IR[20:16], 01 IR[15:11], 10 5'd31, 11 IR[25:21].
- Register file write data (MemtoReg): 0 ALUOut, 1 MDR.
- Register 0 reads 0 always. Writes to register 0 are discarded.
- PC next value (PCSource): 00 ALU result, 01 ALUOut, 10 {PC[31:28], IR[25:0], 2'b00}, 11 PC (hold).
- PC loads when i_PCWrite | (i_PCWriteCond & o_zero).
- IR loads i_mem_rdata when i_IRWrite.
- MDR, A (rf[IR[25:21]]), B (rf[IR[20:16]]) and ALUOut (ALU result) load unconditionally every cycle.
- Register file writes on the edge when i_RegWrite=1. Reads are combinational and see the old value in the write cycle.

## Timing
- Reset (async, i_rst_n=0):
  - PC=RESET_PC.
  - IR, MDR, A, B, ALUOut = 0.
  - All 32 registers = 0.
  - o_op=0, o_funct=0.
  - o_zero reflects the reset-state ALU inputs.
  - o_mem_rd and o_mem_wr follow their inputs.
- Reset asserted mid-instruction discards all in-flight register values immediately. There is no partial writeback.
- Fetch cycle (IorD=0, IRWrite=1, PCWrite=1, SrcA=00, SrcB=01, ALUOp=000): at the edge, IR←mem[PC] and PC←PC+4.
- Decode cycle: A/B hold new rs/rt values at the end of this cycle. ALUOut ← PC + (imm<<2).
- Data loaded from memory is usable from MDR one cycle after the access cycle.
- ALUOut is usable one cycle after its ALU cycle.
- Branch (PCWriteCond=1): o_zero is evaluated on the same-cycle ALU result. The PC update occurs at that edge.
- Simultaneous PCWrite and PCWriteCond: PC loads (OR).
- Simultaneous RegWrite to register r and read of r: the read returns the old value. The new value is visible next cycle.
- MemWrite: memory captures o_mem_wdata at o_mem_addr on the edge. The datapath itself holds no write state.

## Test plan
- Reset with RESET_PC=32'h100 → o_pc=32'h100, o_ir=0, rf[5] reads 0. Assert reset mid-sequence after PC reaches 32'h108 → PC returns to 32'h100 asynchronously.
- Fetch with mem[0]=32'h3108_00F0 (ANDI r8,r8,0xF0) → IR=32'h3108_00F0, PC=4, o_op=6'b001100. With rf[8]=32'hFFFF_FFFF, ALUSrcA=01, ALUSrcB=10, ALUOp=011, then RegWrite with RegDst=00 → rf[8]=32'h0000_00F0 (zero-extended immediate).
- SLTI with rs=-5 (32'hFFFF_FFFB), imm=16'hFFFF (-1), ALUOp=100 → ALUOut=1, o_zero=0. With rs=3 → ALUOut=0, o_zero=1.
- Branch: PCWriteCond=1, PCSource=01, ALUOut=32'h40, ALU result zero → PC=32'h40. Same cycle with nonzero result → PC unchanged.
- Load: IorD=1, ALUOut=32'h20, mem[0x20]=32'hDEAD_BEEF, next cycle MemtoReg=1, RegDst=01, rd=9, RegWrite → rf[9]=32'hDEAD_BEEF. Next cycle ALUSrcA=11, ALUSrcB=00 with rt=32'h10 → ALUOut=32'h14.
- Write to register 0 with 32'h1234 → rf[0] still reads 0. Same-cycle write/read of r3 → old value returned, new value visible next cycle.

Source files
------------

// File: rtl/multicycle_datapath.sv
// Multicycle CPU datapath: PC/IR/MDR/A/B/ALUOut registers, 32x32 register file and ALU.
// Consumes the per-cycle control word and drives one unified instruction/data memory port.
module multicycle_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_PCWrite,
  input  logic        i_PCWriteCond,
  input  logic        i_IorD,
  input  logic        i_MemRead,
  input  logic        i_MemWrite,
  input  logic        i_MemtoReg,
  input  logic        i_IRWrite,
  input  logic        i_RegWrite,
  input  logic [1:0]  i_PCSource,
  input  logic [1:0]  i_ALUSrcA,
  input  logic [1:0]  i_ALUSrcB,
  input  logic [1:0]  i_RegDst,
  input  logic [2:0]  i_ALUOp,
  output logic [5:0]  o_op,
  output logic [5:0]  o_funct,
  output logic        o_zero,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  input  logic [31:0] i_mem_rdata,
  output logic [31:0] o_pc,
  output logic [31:0] o_ir
);

  localparam logic [5:0] OP_ANDI = 6'b001100;

  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] alu_out_q, alu_out_d;
  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];

  logic [31:0] imm_sext, imm_ext;
  logic [31:0] src_a, src_b, alu_result;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pc_en;

  // ALU operand selection; ANDI is the only opcode that zero-extends its immediate
  always_comb begin
    imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
    imm_ext  = (ir_q[31:26] == OP_ANDI) ? {16'h0000, ir_q[15:0]} : imm_sext;

    case (i_ALUSrcA)
      2'b00:   src_a = pc_q;
      2'b01:   src_a = a_q;
      2'b10:   src_a = mdr_q;
      default: src_a = 32'd4;
    endcase

    case (i_ALUSrcB)
      2'b00:   src_b = b_q;
      2'b01:   src_b = 32'd4;
      2'b10:   src_b = imm_ext;
      default: src_b = {imm_sext[29:0], 2'b00};
    endcase
  end

  always_comb begin
    case (i_ALUOp)
      3'b000:  alu_result = src_a + src_b;
      3'b001:  alu_result = src_a - src_b;
      3'b010:  alu_result = src_a | src_b;
      3'b011:  alu_result = src_a & src_b;
      3'b100:  alu_result = {31'd0, $signed(src_a) < $signed(src_b)};
      default: alu_result = 32'd0;
    endcase
  end

  assign o_zero = (alu_result == 32'd0);

  always_comb begin
    case (i_RegDst)
      2'b00:   rf_waddr = ir_q[20:16];
      2'b01:   rf_waddr = ir_q[15:11];
      2'b10:   rf_waddr = 5'd31;
      default: rf_waddr = ir_q[25:21];
    endcase
    rf_wdata = i_MemtoReg ? mdr_q : alu_out_q;

    // Register 0 is never written, so it keeps its reset value of zero
    rf_d = rf_q;
    if (i_RegWrite && (rf_waddr != 5'd0)) begin
      rf_d[rf_waddr] = rf_wdata;
    end
  end

  always_comb begin
    pc_en = i_PCWrite | (i_PCWriteCond & o_zero);
    pc_d  = pc_q;
    if (pc_en) begin
      case (i_PCSource)
        2'b00:   pc_d = alu_result;
        2'b01:   pc_d = alu_out_q;
        2'b10:   pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
        default: pc_d = pc_q;
      endcase
    end

    ir_d      = i_IRWrite ? i_mem_rdata : ir_q;
    mdr_d     = i_mem_rdata;
    a_d       = rf_q[ir_q[25:21]];
    b_d       = rf_q[ir_q[20:16]];
    alu_out_d = alu_result;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      mdr_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mdr_q     <= mdr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
      rf_q      <= rf_d;
    end
  end

  assign o_op        = ir_q[31:26];
  assign o_funct     = ir_q[5:0];
  assign o_mem_addr  = i_IorD ? alu_out_q : pc_q;
  assign o_mem_wdata = b_q;
  assign o_mem_rd    = i_MemRead;
  assign o_mem_wr    = i_MemWrite;
  assign o_pc        = pc_q;
  assign o_ir        = ir_q;

endmodule
